// File: rtl/operand_stack.sv
// Operand stack: a LIFO whose top and next-of-top entries are always visible
// on the outputs. Requests that cannot be carried out (a push while full, or a
// pop while empty) are dropped and recorded in sticky overflow/underflow flags.
module operand_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_to_push,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_from_stack,
  output logic [DATA_W-1:0] data_next,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               we_s;
  logic [AW-1:0]      waddr_s;
  logic [AW-1:0]      top_idx_s;
  logic [AW-1:0]      next_idx_s;

  // Low address bits wrap naturally, so count=DEPTH still selects mem[DEPTH-1].
  assign top_idx_s  = count_q[AW-1:0] - AW'(1);
  assign next_idx_s = count_q[AW-1:0] - AW'(2);

  // Next-state, counter, flag and write-port decode for every push/pop combination.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    we_s    = 1'b0;
    waddr_s = count_q[AW-1:0];
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          we_s    = 1'b1;
          waddr_s = {AW{1'b0}};
          count_d = CNT_W'(1);
          state_d = S_ACTIVE;
        end else begin
          we_s    = 1'b0;
        end
        if (pop) begin
          unf_d = 1'b1;
        end else begin
          unf_d = unf_d;
        end
      end
      S_ACTIVE: begin
        if (push && pop) begin
          we_s    = 1'b1;
          waddr_s = top_idx_s;
        end else if (push) begin
          we_s    = 1'b1;
          waddr_s = count_q[AW-1:0];
          count_d = count_q + CNT_W'(1);
          state_d = (count_q == CNT_W'(DEPTH - 1)) ? S_FULL : S_ACTIVE;
        end else if (pop) begin
          count_d = count_q - CNT_W'(1);
          state_d = (count_q == CNT_W'(1)) ? S_EMPTY : S_ACTIVE;
        end else begin
          we_s    = 1'b0;
        end
      end
      S_FULL: begin
        if (push && pop) begin
          we_s    = 1'b1;
          waddr_s = top_idx_s;
        end else if (push) begin
          ovf_d   = 1'b1;
        end else if (pop) begin
          count_d = count_q - CNT_W'(1);
          state_d = S_ACTIVE;
        end else begin
          we_s    = 1'b0;
        end
      end
      default: begin
        state_d = S_EMPTY;
        count_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control state, entry count and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      count_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= data_to_push;
    end
  end

  // Outputs read straight from storage so the ALU never waits for a read cycle.
  always_comb begin
    data_from_stack = (count_q != {CNT_W{1'b0}}) ? mem_q[top_idx_s] : {DATA_W{1'b0}};
    data_next       = (count_q >= CNT_W'(2))     ? mem_q[next_idx_s] : {DATA_W{1'b0}};
  end

  assign count     = count_q;
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign full      = (count_q == CNT_W'(DEPTH));
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack with hand-computed expectations.
module tb_operand_stack;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk;
  logic              reset;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_to_push;
  logic              clr_err;
  logic [DATA_W-1:0] data_from_stack;
  logic [DATA_W-1:0] data_next;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int tests;
  int fails;

  operand_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .data_to_push    (data_to_push),
    .clr_err         (clr_err),
    .data_from_stack (data_from_stack),
    .data_next       (data_next),
    .count           (count),
    .empty           (empty),
    .full            (full),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request; outputs are settled 1 time unit after the edge.
  task automatic step(input logic ps, input logic pp, input logic [7:0] d, input logic ce);
    push = ps; pop = pp; data_to_push = d; clr_err = ce;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_to_push = 8'h00;
  endtask

  task automatic chk_state(input string tag, input logic [4:0] c, input logic [7:0] top,
                           input logic [7:0] nxt, input logic e, input logic f,
                           input logic ov, input logic un);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".top"},   32'(data_from_stack), 32'(top));
    chk({tag, ".next"},  32'(data_next), 32'(nxt));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"},  32'(full), 32'(f));
    chk({tag, ".ovf"},   32'(overflow), 32'(ov));
    chk({tag, ".unf"},   32'(underflow), 32'(un));
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_to_push = 8'h00; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Push three values.
    step(1'b1, 1'b0, 8'h11, 1'b0);
    chk_state("push1", 5'd1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    chk_state("push3", 5'd3, 8'h33, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pop back to empty, then underflow.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pop1", 5'd2, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pop2", 5'd1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pop3", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pop_empty", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Set wins over clear on the same edge; clear alone drops the flag.
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk_state("clr_and_set", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk_state("clr_alone", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Push+pop on empty: push happens, pop is refused.
    step(1'b1, 1'b1, 8'h9C, 1'b0);
    chk_state("pushpop_empty", 5'd1, 8'h9C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk_state("pop_clr", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill the stack with 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
    end
    chk_state("fill", 5'd16, 8'h0F, 8'h0E, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    chk_state("push_full", 5'd16, 8'h0F, 8'h0E, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk_state("replace_full", 5'd16, 8'h55, 8'h0E, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pop_from_full", 5'd15, 8'h0E, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drain to 2 entries (0x00, 0x01) then replace top.
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk_state("drain", 5'd2, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b1, 8'h07, 1'b0);
    chk_state("replace_mid", 5'd2, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle after five pushes.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    end
    chk_state("pre_async", 5'd7, 8'h44, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b0, 8'hE1, 1'b0);
    chk_state("after_rst", 5'd1, 8'hE1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
